pipe_skid_buffer: RTL and testbench

//  Pipeline stage register with a valid/ready handshake on both sides, replacing
//  the bare enable-driven stage flop wherever a stage boundary needs backpressure.
//  It registers the payload and breaks the combinational ready path with a
//  one-entry skid slot. It sits between two pipeline stages, e.g. fetch->decode
//  or decode->execute, with flush driven by the branch/hazard unit.

---
 rtl/pipe_skid_buffer.sv | 110 +++++++++++
 tb/tb_pipe_skid_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
// pipe_skid_buffer : valid/ready pipeline register with a one-entry skid slot
// Revision 1.0
// ============================================================================
module pipe_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_acc_in;
  logic             w_acc_out;
  logic             w_main_from_in;
  logic             w_main_from_skid;
  logic             w_skid_from_in;

  // Handshake outputs depend only on state, so no comb path from out_ready.
  assign in_ready  = (r_state != SKID);
  assign out_valid = (r_state != EMPTY);
  assign count     = r_state;
  assign out_data  = r_main;

  assign w_acc_in  = in_valid & in_ready;
  assign w_acc_out = out_valid & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_acc_in) begin
          w_main_from_in = 1'b1;
          w_next_state   = FULL;
        end
      end
      FULL: begin
        if (w_acc_in && w_acc_out) begin
          w_main_from_in = 1'b1;
        end else if (w_acc_in) begin
          w_skid_from_in = 1'b1;
          w_next_state   = SKID;
        end else if (w_acc_out) begin
          w_next_state = EMPTY;
        end
      end
      SKID: begin
        if (w_acc_out) begin
          w_main_from_skid = 1'b1;
          w_next_state     = FULL;
        end
      end
      default: w_next_state = EMPTY;
    endcase
    // Squash wins over any handshake in the same cycle; the beat is dropped.
    if (flush) begin
      w_next_state     = EMPTY;
      w_main_from_in   = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_from_in) begin
        r_main <= in_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_from_in) begin
        r_skid <= in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
// tb_pipe_skid_buffer : directed and random self-checking bench
// Revision 1.0
// ============================================================================
module tb_pipe_skid_buffer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             resetn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int tests_run;
  int tests_failed;

  pipe_skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Status vector is {out_valid, in_ready, count}.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({out_valid, in_ready, count} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL reset_status: got %b want 0100", {out_valid, in_ready, count});
    end
    tests_run++;
    if (out_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h want 00000000", out_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    // load one beat, then reset asynchronously between edges
    in_valid  = 1'b1;
    in_data   = 32'hCAFE_0001;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, count, out_data} !== {4'b1101, 32'hCAFE_0001}) begin
      tests_failed++;
      $display("FAIL reset_preload: got %b/%h want 1101/cafe0001",
               {out_valid, in_ready, count}, out_data);
    end
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready, count, out_data} !== {4'b0100, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_async: got %b/%h want 0100/00000000",
               {out_valid, in_ready, count}, out_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    tests_run++;
    if ({out_valid, in_ready, count} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL reset_no_partial: got %b want 0100", {out_valid, in_ready, count});
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      tick();
      tests_run++;
      if ({out_valid, in_ready, count, out_data} !== {4'b1101, WIDTH'(i)}) begin
        tests_failed++;
        $display("FAIL stream_beat%0d: got %b/%h want 1101/%h",
                 i, {out_valid, in_ready, count}, out_data, WIDTH'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if ({out_valid, in_ready, count} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL stream_drain: got %b want 0100", {out_valid, in_ready, count});
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    tests_run++;
    if ({out_valid, in_ready, count, out_data} !== {4'b1010, 32'hA}) begin
      tests_failed++;
      $display("FAIL bp_skid: got %b/%h want 1010/0000000a",
               {out_valid, in_ready, count}, out_data);
    end
    // X payload while not ready must be ignored
    in_data = 'x;
    tick();
    tests_run++;
    if ({out_valid, in_ready, count, out_data} !== {4'b1010, 32'hA}) begin
      tests_failed++;
      $display("FAIL bp_x_ignored: got %b/%h want 1010/0000000a",
               {out_valid, in_ready, count}, out_data);
    end
    in_data = 32'hC;
    tick();
    tests_run++;
    if ({out_valid, in_ready, count, out_data} !== {4'b1010, 32'hA}) begin
      tests_failed++;
      $display("FAIL bp_stall_c: got %b/%h want 1010/0000000a",
               {out_valid, in_ready, count}, out_data);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if ({out_valid, in_ready, count, out_data} !== {4'b1101, 32'hB}) begin
      tests_failed++;
      $display("FAIL bp_release_b: got %b/%h want 1101/0000000b",
               {out_valid, in_ready, count}, out_data);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, count, out_data} !== {4'b1101, 32'hC}) begin
      tests_failed++;
      $display("FAIL bp_release_c: got %b/%h want 1101/0000000c",
               {out_valid, in_ready, count}, out_data);
    end
    tick();
    tests_run++;
    if ({out_valid, in_ready, count} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL bp_drain: got %b want 0100", {out_valid, in_ready, count});
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    flush   = 1'b1;
    in_data = 32'hD;
    tick();
    tests_run++;
    if ({out_valid, in_ready, count} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL flush_from_skid: got %b want 0100", {out_valid, in_ready, count});
    end
    // flush while empty and ready: the presented beat is dropped
    in_data = 32'hE;
    tick();
    tests_run++;
    if ({out_valid, in_ready, count} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL flush_drop_beat: got %b want 0100", {out_valid, in_ready, count});
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tests_run++;
    if ({out_valid, in_ready, count} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL flush_no_output: got %b want 0100", {out_valid, in_ready, count});
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    tick();
    in_data   = 32'h6;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if ({out_valid, in_ready, count, out_data} !== {4'b1101, 32'h6}) begin
      tests_failed++;
      $display("FAIL simul_replace: got %b/%h want 1101/00000006",
               {out_valid, in_ready, count}, out_data);
    end
    tick();
    tests_run++;
    if ({out_valid, in_ready, count, out_data} !== {4'b1101, 32'h6}) begin
      tests_failed++;
      $display("FAIL simul_hold: got %b/%h want 1101/00000006",
               {out_valid, in_ready, count}, out_data);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if ({out_valid, in_ready, count} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL simul_drain: got %b want 0100", {out_valid, in_ready, count});
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] q[$];
    logic             exp_ov;
    logic             exp_ir;
    logic [1:0]       exp_cnt;
    logic             acc_in;
    logic             acc_out;
    int               rand_fails;
    rand_fails = 0;
    flush      = 1'b1;
    in_valid   = 1'b0;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 10000 && rand_fails < 20; c++) begin
      exp_ov  = (q.size() != 0);
      exp_ir  = (q.size() < 2);
      exp_cnt = 2'(q.size());
      tests_run++;
      if ({out_valid, in_ready, count} !== {exp_ov, exp_ir, exp_cnt}) begin
        tests_failed++;
        rand_fails++;
        $display("FAIL rand_status@%0d: got %b want %b",
                 c, {out_valid, in_ready, count}, {exp_ov, exp_ir, exp_cnt});
      end
      if (exp_ov) begin
        tests_run++;
        if (out_data !== q[0]) begin
          tests_failed++;
          rand_fails++;
          $display("FAIL rand_data@%0d: got %h want %h", c, out_data, q[0]);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = exp_ir ? WIDTH'($urandom) : 'x;
      acc_in    = in_valid && exp_ir;
      acc_out   = exp_ov && out_ready;
      tick();
      if (flush) begin
        q.delete();
      end else begin
        if (acc_out) void'(q.pop_front());
        if (acc_in) q.push_back(in_data);
      end
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tests_run    = 0;
    tests_failed = 0;
    #12;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
